imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the byte-addressed instruction memory.
- Accepts 32-bit instruction words on a valid/ready stream and writes each one into the instruction memory as four little-endian byte writes: byte 0 goes to addr+0, and so on.
- Holds the core in reset while a load is in progress.
- Reports the word count, a running checksum and an overflow error.

Parameters:
MEM_BYTES, 88, instruction memory depth in bytes (22 words); byte addresses 0..MEM_BYTES-1 are legal.
CNT_W, 16, width of word_count.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
load_start  in  1  single-cycle pulse; starts or restarts a load.
s_valid  in  1  stream word valid.
s_ready  out  1  loader can accept a word.
s_data  in  32  instruction word.
s_last  in  1  marks the final word of the program; qualified by s_valid.
mem_we  out  1  byte write enable to the instruction memory.
mem_addr  out  32  byte address of the current write.
mem_wdata  out  8  byte being written.
cpu_hold  out  1  core held in reset while high.
load_done  out  1  sticky; program loaded successfully.
load_err  out  1  sticky; word would exceed MEM_BYTES.
word_count  out  CNT_W  number of words fully written.
checksum  out  32  sum mod 2^32 of all fully written words.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, word_count=0, checksum=0.
- Reset asserted mid-load: all of the above take effect immediately and asynchronously. mem_we drops without waiting for a clock edge, and the partial word is abandoned.

States: IDLE, ACCEPT, WRITE, DONE, ERROR.

load_start, checked in any state, has priority over everything else. On the next edge:
- state -> ACCEPT, base address -> 0, word_count -> 0, checksum -> 0.
- load_done -> 0, load_err -> 0, cpu_hold -> 1.
- If load_start arrives mid-WRITE, the remaining bytes of that word are not written.

IDLE:
- s_ready=0, mem_we=0.
- Waits for load_start.

ACCEPT:
- s_ready=1 (Moore output, registered state decode), mem_we=0.
- On s_valid && s_ready, one of two things happens:
  - If base+3 > MEM_BYTES-1: state -> ERROR. No memory write, and counters are unchanged.
  - Otherwise: latch s_data and s_last, beat -> 0, state -> WRITE.
- s_data and s_last are sampled only on the handshake edge. Values presented while s_ready=0 are ignored.

WRITE:
- Lasts exactly 4 cycles. In each cycle: s_ready=0, mem_we=1, mem_addr=base+beat, mem_wdata=word[8*beat+7:8*beat], for beat = 0,1,2,3.
- On the edge that ends beat 3: base += 4, word_count += 1, checksum += word (wraps mod 2^32).
- Next state: DONE if the latched last flag is 1, otherwise ACCEPT.
- Throughput: 5 cycles per word (1 accept cycle + 4 write cycles). Back-to-back valid stalls only through s_ready.

DONE:
- Lasts one cycle. load_done -> 1 (sticky), cpu_hold -> 0, state -> IDLE.

ERROR:
- load_err=1 (sticky), cpu_hold stays 1, s_ready=0, mem_we=0.
- Only load_start or reset leaves this state.

Other rules:
- A word that exactly fills the memory (base = MEM_BYTES-4) is legal.
- The check for the next word (base+3 > MEM_BYTES-1) flags it, even if it carries s_last.
- s_last with no further words is normal completion. A missing s_last leaves the loader in ACCEPT indefinitely, with cpu_hold=1.
- word_count and checksum hold their values after DONE or ERROR until the next load_start.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
1. Basic load:
   - Stimulus: reset, load_start, then one word 32'h00000913 with s_last=1.
   - Required: mem_we for 4 cycles with writes (0,13),(1,09),(2,00),(3,00). Then load_done=1, cpu_hold=0, word_count=1, checksum=32'h00000913.
2. Full program:
   - Stimulus: stream 22 words, the last one 32'hfa000ae3 with s_last=1.
   - Required: final write is byte 87 = 8'hfa, word_count=22, checksum equals the mod 2^32 sum of all 22 words, load_err=0.
3. Overflow:
   - Stimulus: 23 words with MEM_BYTES=88.
   - Required: the 23rd handshake -> ERROR, load_err=1, no mem_we after address 87, cpu_hold stays 1, word_count=22.
4. Backpressure and gaps:
   - Stimulus: s_valid held high continuously, and separately with random idle cycles.
   - Required: exactly one handshake per 5 cycles at most, s_ready=0 throughout WRITE, no dropped or duplicated bytes.
5. Reset mid-load:
   - Stimulus: assert rst_n=0 during beat 2 of word 3.
   - Required: mem_we drops before the next edge, and all outputs return to their reset values.
6. Restart:
   - Stimulus: load_start during WRITE of word 2.
   - Required: no further bytes of that word are written, counters clear, and the next accepted word is written at address 0.

Source files
------------

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Streams 32-bit instruction words into a byte-addressed
//           instruction memory as four little-endian byte writes, holding
//           the core in reset for the duration of the load.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int MEM_BYTES = 88,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] word_count,
    output logic [31:0]      checksum
);

    localparam logic [2:0]       c_idle     = 3'd0;
    localparam logic [2:0]       c_accept   = 3'd1;
    localparam logic [2:0]       c_write    = 3'd2;
    localparam logic [2:0]       c_done     = 3'd3;
    localparam logic [2:0]       c_error    = 3'd4;
    localparam logic [31:0]      c_max_addr = 32'(MEM_BYTES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [1:0]       r_beat;
    logic [31:0]      r_base;
    logic [31:0]      r_word;
    logic [23:0]      r_shift;
    logic             r_last;
    logic             r_s_ready;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [7:0]       r_mem_wdata;
    logic             r_cpu_hold;
    logic             r_load_done;
    logic             r_load_err;
    logic [CNT_W-1:0] r_word_count;
    logic [31:0]      r_checksum;

    logic             w_overflow;

    // The whole word must fit: its top byte lands at base+3.
    assign w_overflow = (r_base + 32'd3) > c_max_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_beat       <= 2'd0;
            r_base       <= 32'd0;
            r_word       <= 32'd0;
            r_shift      <= 24'd0;
            r_last       <= 1'b0;
            r_s_ready    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 8'd0;
            r_cpu_hold   <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_word_count <= '0;
            r_checksum   <= 32'd0;
        end else if (load_start) begin
            // Restart abandons any word still being written.
            r_state      <= c_accept;
            r_base       <= 32'd0;
            r_word_count <= '0;
            r_checksum   <= 32'd0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_s_ready    <= 1'b1;
            r_mem_we     <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_s_ready <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
                c_accept: begin
                    if (s_valid && r_s_ready) begin
                        r_s_ready <= 1'b0;
                        if (w_overflow) begin
                            r_state    <= c_error;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state     <= c_write;
                            r_word      <= s_data;
                            r_shift     <= s_data[31:8];
                            r_last      <= s_last;
                            r_beat      <= 2'd0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_base;
                            r_mem_wdata <= s_data[7:0];
                        end
                    end
                end
                c_write: begin
                    if (r_beat == 2'd3) begin
                        r_mem_we     <= 1'b0;
                        r_base       <= r_base + 32'd4;
                        r_word_count <= r_word_count + c_cnt_one;
                        r_checksum   <= r_checksum + r_word;
                        if (r_last) begin
                            r_state <= c_done;
                        end else begin
                            r_state   <= c_accept;
                            r_s_ready <= 1'b1;
                        end
                    end else begin
                        r_beat      <= r_beat + 2'd1;
                        r_mem_addr  <= r_base + {30'd0, r_beat + 2'd1};
                        r_mem_wdata <= r_shift[7:0];
                        r_shift     <= {8'd0, r_shift[23:8]};
                    end
                end
                c_done: begin
                    r_load_done <= 1'b1;
                    r_cpu_hold  <= 1'b0;
                    r_state     <= c_idle;
                end
                c_error: begin
                    r_s_ready <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign word_count = r_word_count;
    assign checksum   = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Scoreboard bench for imem_loader; expected byte writes are queued
//           as words are offered and matched against observed writes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int MEM_BYTES = 88;
    localparam int CNT_W     = 16;

    logic             clk;
    logic             rst_n;
    logic             load_start;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             s_last;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic             cpu_hold;
    logic             load_done;
    logic             load_err;
    logic [CNT_W-1:0] word_count;
    logic [31:0]      checksum;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_base = 32'd0;
    logic [31:0] m_sum  = 32'd0;
    int          m_count = 0;
    int          cyc = 0;
    int          last_hs = -100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake spacing: a new word may be taken at most once every 5 cycles.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && load_start) begin
            last_hs = -100;
        end else if (rst_n && s_valid && s_ready) begin
            n_checks++;
            if (cyc - last_hs < 5) begin
                n_errors++;
                $display("FAIL hs_spacing: gap %0d cycles, required >= 5", cyc - last_hs);
            end
            last_hs = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: addr %0d data %h, required no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    n_errors++;
                    $display("FAIL byte_write: got (%0d,%h), required (%0d,%h)",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
            n_checks++;
            if (s_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL ready_in_write: s_ready %b, required 0", s_ready);
            end
        end
    end

    task automatic model_clear();
        m_base  = 32'd0;
        m_sum   = 32'd0;
        m_count = 0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        model_clear();
    endtask

    // Offers one word; returns on the negedge after the handshake edge.
    task automatic send_word(input logic [31:0] d, input logic last, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: s_ready %b after %0d cycles, required 1", s_ready, n);
            s_valid = 1'b0;
            return;
        end
        if (m_base + 32'd3 <= 32'(MEM_BYTES - 1)) begin
            for (int b = 0; b < 4; b++)
                exp_q.push_back(wr_t'{m_base + 32'(b), d[8*b +: 8]});
            m_base  = m_base + 32'd4;
            m_sum   = m_sum + d;
            m_count = m_count + 1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (load_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (load_done === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, word_count, checksum} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: s_ready %b we %b addr %h wdata %h hold %b done %b err %b cnt %0d sum %h, required all 0",
                     s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, word_count, checksum);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_outputs: s_ready %b hold %b we %b, required 0 0 0", s_ready, cpu_hold, mem_we);
        end
    endtask

    task automatic test_basic();
        bit ok;
        pulse_start();
        n_checks++;
        if (cpu_hold !== 1'b1 || s_ready !== 1'b1 || load_done !== 1'b0) begin
            n_errors++;
            $display("FAIL start_state: hold %b ready %b done %b, required 1 1 0", cpu_hold, s_ready, load_done);
        end
        send_word(32'h00000913, 1'b1, 0);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL basic_done_timeout: load_done %b, required 1", load_done);
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || word_count !== 16'd1 || checksum !== 32'h00000913 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL basic_result: hold %b cnt %0d sum %h pending %0d, required 0 1 00000913 0",
                     cpu_hold, word_count, checksum, exp_q.size());
        end
    endtask

    task automatic test_full();
        bit ok;
        pulse_start();
        for (int i = 0; i < 21; i++) send_word($urandom, 1'b0, 0);
        send_word(32'hfa000ae3, 1'b1, 0);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL full_done_timeout: load_done %b, required 1", load_done);
        end
        n_checks++;
        if (word_count !== 16'd22 || checksum !== m_sum || load_err !== 1'b0) begin
            n_errors++;
            $display("FAIL full_result: cnt %0d sum %h err %b, required 22 %h 0", word_count, checksum, load_err, m_sum);
        end
        n_checks++;
        if (mem_addr !== 32'd87 || mem_wdata !== 8'hfa || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL full_last_byte: addr %0d data %h pending %0d, required 87 fa 0", mem_addr, mem_wdata, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 22; i++) send_word($urandom, 1'b0, 0);
        send_word($urandom, 1'b1, 0);
        repeat (8) @(negedge clk);
        n_checks++;
        if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_flags: err %b hold %b done %b, required 1 1 0", load_err, cpu_hold, load_done);
        end
        n_checks++;
        if (word_count !== 16'd22 || checksum !== m_sum || s_ready !== 1'b0 || mem_we !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL ovf_counts: cnt %0d sum %h ready %b we %b pending %0d, required 22 %h 0 0 0",
                     word_count, checksum, s_ready, mem_we, exp_q.size(), m_sum);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        pulse_start();
        n_checks++;
        if (load_err !== 1'b0 || word_count !== 16'd0 || checksum !== 32'd0) begin
            n_errors++;
            $display("FAIL restart_from_error: err %b cnt %0d sum %h, required 0 0 0", load_err, word_count, checksum);
        end
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 0);
        for (int i = 0; i < 5; i++) send_word($urandom, (i == 4), $urandom_range(0, 4));
        wait_done(ok);
        n_checks++;
        if (!ok || word_count !== 16'd10 || checksum !== m_sum || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL gaps_result: done %b cnt %0d sum %h pending %0d, required 1 10 %h 0",
                     load_done, word_count, checksum, exp_q.size(), m_sum);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_word($urandom, 1'b0, 0);
        send_word($urandom, 1'b0, 0);
        send_word($urandom, 1'b0, 0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'd10) begin
            n_errors++;
            $display("FAIL beat2_position: we %b addr %0d, required 1 10", mem_we, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_clear();
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL async_we_drop: mem_we %b, required 0", mem_we);
        end
        n_checks++;
        if ({s_ready, mem_addr, mem_wdata, cpu_hold, load_done, load_err, word_count, checksum} !== '0) begin
            n_errors++;
            $display("FAIL async_reset_values: ready %b addr %h wdata %h hold %b done %b err %b cnt %0d sum %h, required all 0",
                     s_ready, mem_addr, mem_wdata, cpu_hold, load_done, load_err, word_count, checksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cpu_hold !== 1'b0 || s_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: hold %b ready %b we %b, required 0 0 0", cpu_hold, s_ready, mem_we);
        end
    endtask

    task automatic test_restart();
        bit ok;
        pulse_start();
        send_word($urandom, 1'b0, 0);
        send_word($urandom, 1'b0, 0);
        @(negedge clk);
        load_start = 1'b1;
        #1;
        exp_q.delete();
        @(negedge clk);
        load_start = 1'b0;
        model_clear();
        n_checks++;
        if (word_count !== 16'd0 || checksum !== 32'd0 || cpu_hold !== 1'b1 || s_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_state: cnt %0d sum %h hold %b ready %b we %b, required 0 0 1 1 0",
                     word_count, checksum, cpu_hold, s_ready, mem_we);
        end
        send_word($urandom, 1'b1, 0);
        wait_done(ok);
        n_checks++;
        if (!ok || word_count !== 16'd1 || checksum !== m_sum || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL restart_result: done %b cnt %0d sum %h pending %0d, required 1 1 %h 0",
                     load_done, word_count, checksum, exp_q.size(), m_sum);
        end
    endtask

    initial begin
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        s_data     = 32'd0;
        rst_n      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_restart();
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_writes: pending %0d, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
